mem_arbiter: RTL and testbench

Sequencer and arbiter for the single unified memory of the multicycle CPU. It sits between the memory array and two requesters: the CPU control unit's fetch/load/store path (port `cpu`) and the program-loader/DMA port (port `dma`). It owns every memory strobe, runs each access for a fixed number of wait cycles and returns a one-cycle done pulse. While its port is not being served it holds the CPU in a stall, so the control unit's state does not advance.

---
 rtl/mem_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: access sequencer and two-port arbiter for the unified memory
// of the multicycle CPU.
//
// Every access follows the same sequence:
//   IDLE -> BUSY (MEM_LAT cycles) -> RESP (one cycle) -> IDLE.
// The winning port's request is captured when the access is granted in IDLE.
// The memory strobes are high only while the FSM is in BUSY. The read data is
// captured at the edge that leaves BUSY. A one-cycle done pulse goes to the
// served port during RESP.
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to build the DMA
// starvation guard. When it is undefined the CPU has strict priority.
//
// Parameters
//   ADDR_W     address width
//   DATA_W     data width
//   MEM_LAT    number of memory access cycles (>= 1)
//   STARVE_MAX consecutive contested CPU grants tolerated before DMA is
//              forced through (1..7; only used with the guard built)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   cpu_*      CPU request port (req/we/addr/wdata)
//   dma_*      DMA request port (req/we/addr/wdata)
//   mem_rdata  memory read data, valid in the last access cycle
//   mem_read   memory read strobe (registered)
//   mem_write  memory write strobe (registered)
//   mem_addr   memory address (registered)
//   mem_wdata  memory write data (registered)
//   cpu_done   one-cycle completion pulse for the CPU port (registered)
//   dma_done   one-cycle completion pulse for the DMA port (registered)
//   rdata      captured read data, valid while a done pulse is high
//   cpu_stall  cpu_req & ~cpu_done (combinational)

module mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_done,
  output logic              dma_done,
  output logic [DATA_W-1:0] rdata,
  output logic              cpu_stall
);

  // A width of at least one bit is kept even when MEM_LAT is 1.
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_ZERO = LAT_W'(0);

  // Stop elaboration if the parameters are out of range.
  if ((MEM_LAT < 1) || (STARVE_MAX < 1) || (STARVE_MAX > 7)) begin : g_param_check
    $error("mem_arbiter: MEM_LAT must be >= 1 and STARVE_MAX must be in 1..7");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r,     state_s;
  logic [LAT_W-1:0]  lat_cnt_r,   lat_cnt_s;
  logic              dma_sel_r,   dma_sel_s;     // latched winner, 1 = DMA
  logic              we_r,        we_s;
  logic [ADDR_W-1:0] addr_r,      addr_s;
  logic [DATA_W-1:0] wdata_r,     wdata_s;
  logic [DATA_W-1:0] rdata_r,     rdata_s;
  logic              mem_read_r,  mem_read_s;
  logic              mem_write_r, mem_write_s;
  logic              cpu_done_r,  cpu_done_s;
  logic              dma_done_r,  dma_done_s;
  logic              grant_s;
  logic              dma_win_s;

  // A grant happens in IDLE whenever either port requests.
  assign grant_s = (state_r == ST_IDLE) && (cpu_req || dma_req);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_cnt_r, starve_cnt_s;

  // Arbitration decision: CPU first, unless DMA has waited STARVE_MAX grants.
  always_comb begin
    dma_win_s = dma_req && (!cpu_req || (starve_cnt_r == STARVE_LIM));
  end

  // Count CPU grants taken while DMA was waiting. Saturate at STARVE_LIM.
  always_comb begin
    starve_cnt_s = starve_cnt_r;
    if (grant_s) begin
      if (dma_win_s || !dma_req) begin
        starve_cnt_s = 3'd0;
      end else if (starve_cnt_r != STARVE_LIM) begin
        starve_cnt_s = starve_cnt_r + 3'd1;
      end else begin
        starve_cnt_s = starve_cnt_r;
      end
    end else begin
      starve_cnt_s = starve_cnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= 3'd0;
    end else begin
      starve_cnt_r <= starve_cnt_s;
    end
  end
`else
  // Arbitration decision: strict CPU priority.
  always_comb begin
    dma_win_s = dma_req && !cpu_req;
  end
`endif

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_s     = state_r;
    lat_cnt_s   = lat_cnt_r;
    dma_sel_s   = dma_sel_r;
    we_s        = we_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    rdata_s     = rdata_r;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    cpu_done_s  = 1'b0;
    dma_done_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_s   = ST_BUSY;
          lat_cnt_s = LAT_LOAD;
          dma_sel_s = dma_win_s;
          if (dma_win_s) begin
            we_s    = dma_we;
            addr_s  = dma_addr;
            wdata_s = dma_wdata;
          end else begin
            we_s    = cpu_we;
            addr_s  = cpu_addr;
            wdata_s = cpu_wdata;
          end
          // The strobes are registered, so they rise with the first BUSY cycle.
          mem_read_s  = !we_s;
          mem_write_s = we_s;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (lat_cnt_r == LAT_ZERO) begin
          // Last access cycle: mem_rdata is valid now.
          state_s = ST_RESP;
          if (!we_r) begin
            rdata_s = mem_rdata;
          end else begin
            rdata_s = rdata_r;
          end
          cpu_done_s = !dma_sel_r;
          dma_done_s = dma_sel_r;
        end else begin
          lat_cnt_s   = lat_cnt_r - LAT_ONE;
          mem_read_s  = !we_r;
          mem_write_s = we_r;
        end
      end

      // Mandatory turnaround cycle. Request inputs are ignored here.
      ST_RESP: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered-output update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      lat_cnt_r   <= LAT_ZERO;
      dma_sel_r   <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      cpu_done_r  <= 1'b0;
      dma_done_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      lat_cnt_r   <= lat_cnt_s;
      dma_sel_r   <= dma_sel_s;
      we_r        <= we_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      rdata_r     <= rdata_s;
      mem_read_r  <= mem_read_s;
      mem_write_r <= mem_write_s;
      cpu_done_r  <= cpu_done_s;
      dma_done_r  <= dma_done_s;
    end
  end

  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign cpu_done  = cpu_done_r;
  assign dma_done  = dma_done_r;
  assign rdata     = rdata_r;
  assign cpu_stall = cpu_req && !cpu_done_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with MEM_LAT=2 and STARVE_MAX=4.
// Stimulus pushes the hand-computed expected access for each request into
// exp_q. A monitor process checks the strobes against the head entry and
// pops that entry on each done pulse.

module tb_mem_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0]  cpu_addr, dma_addr, mem_addr;
  logic [15:0] cpu_wdata, dma_wdata, mem_rdata, mem_wdata, rdata;
  logic        mem_read, mem_write, cpu_done, dma_done, cpu_stall;

  typedef struct {
    logic        is_dma;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle_cnt   = 0;
  bit   b2b_mode    = 1'b0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_done(cpu_done),
    .dma_done(dma_done), .rdata(rdata), .cpu_stall(cpu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed memory contents, looked up from the address the DUT drives.
  always_comb begin
    case (mem_addr)
      8'h12:   mem_rdata = 16'hBEEF;
      8'h34:   mem_rdata = 16'hCAFE;
      default: mem_rdata = {8'hA5, mem_addr};
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic push_exp(input logic is_dma, input logic we, input logic [7:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rdata);
    exp_t e;
    e.is_dma = is_dma;
    e.we     = we;
    e.addr   = addr;
    e.wdata  = wdata;
    e.rdata  = exp_rdata;
    exp_q.push_back(e);
  endtask

  // Wait for the done pulse of one port, then step to just after the next edge.
  task automatic wait_done(input logic is_dma);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = is_dma ? dma_done : cpu_done;
    end
    if (!seen) fail_now(is_dma ? "timeout_dma_done" : "timeout_cpu_done");
    @(posedge clk);
    #1;
  endtask

  // Wait for the first strobe cycle, sampled at a falling edge.
  task automatic wait_strobe();
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = mem_read || mem_write;
    end
    if (!seen) fail_now("timeout_strobe");
  endtask

  // Wait for a given number of done pulses from either port.
  task automatic wait_dones(input int count);
    int got = 0;
    for (int n = 0; n < 200 && got < count; n++) begin
      @(negedge clk);
      if (cpu_done || dma_done) got++;
    end
    if (got < count) fail_now("timeout_done_sequence");
    @(posedge clk);
    #1;
  endtask

  // Run one access from a single port.
  task automatic do_single(input logic is_dma, input logic we, input logic [7:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rdata);
    push_exp(is_dma, we, addr, wdata, exp_rdata);
    if (is_dma) begin
      dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    wait_done(is_dma);
    if (is_dma) dma_req = 1'b0;
    else        cpu_req = 1'b0;
  endtask

  // Monitor: checks the strobes and done pulses against the scoreboard head.
  initial begin : monitor
    exp_t e;
    int   strobe_len = 0;
    int   prev_done  = 0;
    bit   prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      cycle_cnt++;
      if (!reset) begin
        check("rst_mem_read",  32'(mem_read),  32'h0);
        check("rst_mem_write", 32'(mem_write), 32'h0);
        check("rst_cpu_done",  32'(cpu_done),  32'h0);
        check("rst_dma_done",  32'(dma_done),  32'h0);
        strobe_len = 0;
        prev_valid = 1'b0;
      end else begin
        if (mem_read || mem_write) begin
          if (exp_q.size() == 0) begin
            fail_now("strobe_without_request");
          end else begin
            e = exp_q[0];
            check("strobe_addr",  32'(mem_addr),  32'(e.addr));
            check("strobe_write", 32'(mem_write), 32'(e.we));
            check("strobe_read",  32'(mem_read),  32'(!e.we));
            if (e.we) check("strobe_wdata", 32'(mem_wdata), 32'(e.wdata));
            strobe_len++;
          end
        end
        if (cpu_done || dma_done) begin
          check("done_onehot", 32'(cpu_done && dma_done), 32'h0);
          if (exp_q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            e = exp_q.pop_front();
            check("done_port",     32'(dma_done), 32'(e.is_dma));
            check("done_rdata",    32'(rdata),    32'(e.rdata));
            check("strobe_cycles", 32'(strobe_len), 32'(MEM_LAT));
            check("resp_no_strobe", 32'(mem_read || mem_write), 32'h0);
            if (cpu_done) check("stall_low_on_done", 32'(cpu_stall), 32'h0);
            if (b2b_mode && prev_valid)
              check("done_spacing", 32'(cycle_cnt - prev_done), 32'(MEM_LAT + 2));
          end
          strobe_len = 0;
          prev_done  = cycle_cnt;
          prev_valid = b2b_mode;
        end
      end
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time bound expired");
  end

  // Directed stimulus.
  initial begin
    reset     = 1'b0;
    cpu_req   = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12; cpu_wdata = 16'h0000;
    dma_req   = 1'b1; dma_we = 1'b1; dma_addr = 8'h40; dma_wdata = 16'h1234;

    // Both requests are present during reset. CPU wins first, then the DMA
    // write runs and leaves rdata at the CPU's 0xBEEF.
    push_exp(1'b0, 1'b0, 8'h12, 16'h0000, 16'hBEEF);
    push_exp(1'b1, 1'b1, 8'h40, 16'h1234, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rdata",     32'(rdata),     32'h0);
      check("rst_mem_addr",  32'(mem_addr),  32'h0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
      check("rst_cpu_stall", 32'(cpu_stall), 32'h1);
    end
    @(posedge clk);
    #1 reset = 1'b1;

    // Change cpu_addr during BUSY. The latched 0x12 must stay on mem_addr.
    wait_strobe();
    check("stall_during_access", 32'(cpu_stall), 32'h1);
    cpu_addr = 8'h99;
    wait_done(1'b0);
    cpu_req  = 1'b0;
    cpu_addr = 8'h12;
    wait_done(1'b1);
    dma_req = 1'b0;

    // Pull reset low in the second BUSY cycle. After release the access is
    // served again with full latency.
    push_exp(1'b0, 1'b0, 8'h34, 16'h0000, 16'hCAFE);
    cpu_we = 1'b0; cpu_addr = 8'h34; cpu_req = 1'b1;
    wait_strobe();
    @(negedge clk);
    check("second_busy_cycle", 32'(mem_read), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("abort_mem_read", 32'(mem_read), 32'h0);
    check("abort_cpu_done", 32'(cpu_done), 32'h0);
    check("abort_rdata",    32'(rdata),    32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wait_done(1'b0);
    cpu_req = 1'b0;

    // Single-port accesses: a CPU write leaves rdata alone, then a DMA read.
    do_single(1'b0, 1'b1, 8'h21, 16'h0F0F, 16'hCAFE);
    do_single(1'b1, 1'b0, 8'h77, 16'h0000, 16'hA577);

    // Both ports request back to back. CPU reads 0x12; DMA writes 0x50.
    b2b_mode = 1'b1;
    cpu_we = 1'b0; cpu_addr = 8'h12; cpu_wdata = 16'h0000;
    dma_we = 1'b1; dma_addr = 8'h50; dma_wdata = 16'h5555;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push_exp(1'b1, 1'b1, 8'h50, 16'h5555, 16'hBEEF);
      else                  push_exp(1'b0, 1'b0, 8'h12, 16'h0000, 16'hBEEF);
    end
    cpu_req = 1'b1; dma_req = 1'b1;
    wait_dones(10);
    cpu_req = 1'b0; dma_req = 1'b0;
`else
    for (int k = 0; k < 10; k++) push_exp(1'b0, 1'b0, 8'h12, 16'h0000, 16'hBEEF);
    push_exp(1'b1, 1'b1, 8'h50, 16'h5555, 16'hBEEF);
    cpu_req = 1'b1; dma_req = 1'b1;
    wait_dones(10);
    cpu_req = 1'b0;
    wait_done(1'b1);
    dma_req = 1'b0;
`endif
    b2b_mode = 1'b0;

    repeat (6) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
